// File: rtl/board_ctrl_pkg.sv
// Shared types and default 14.318 MHz timing constants for board_ctrl.
package board_ctrl_pkg;

    typedef enum logic [1:0] {
        POR_HOLD  = 2'd0,
        POR_COUNT = 2'd1,
        POR_RUN   = 2'd2
    } por_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES     = 143180;
    localparam int unsigned DEF_POR_CYCLES          = 4194304;
    localparam int unsigned DEF_FLASH_HALF_CYCLES   = 3579545;
    localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 7159090;
    localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 1431818;

    // Counter width for a counter that wraps/clears at terminal-1.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/board_ctrl_key.sv
// One push button: 2-flop synchroniser, polarity normalisation, debounce,
// press/release strobes and (with BOARD_CTRL_KEY_REPEAT_EN) auto-repeat.
module key_debounce
    import board_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
    parameter bit          ACTIVE_LOW          = 1'b1,
    parameter bit          REPEAT_ALLOW        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic press_stb,
    output logic release_stb
);

    localparam logic        IDLE_RAW = ACTIVE_LOW;
    localparam int unsigned DB_W     = cnt_width(DEBOUNCE_CYCLES);

    // Reject timing values that would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 1 ||
        (REPEAT_ALLOW && (REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1))) begin : g_bad_cfg
        $error("key_debounce: cycle counts must be at least 1");
    end

    logic            sync1;
    logic            sync2;
    logic            sampled;
    logic [DB_W-1:0] db_cnt;
    logic            commit_c;
    logic            rpt_fire_c;

    assign commit_c = (sampled != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

    // Synchronise the raw level and register it as pressed = 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= IDLE_RAW;
            sync2   <= IDLE_RAW;
            sampled <= 1'b0;
        end else begin
            sync1   <= key_raw;
            sync2   <= sync1;
            sampled <= sync2 ^ ACTIVE_LOW;
        end
    end

    // Debounce counter: count while the sample disagrees, commit at terminal.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt      <= '0;
            level       <= 1'b0;
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
        end else begin
            press_stb   <= (commit_c && !level) || rpt_fire_c;
            release_stb <= commit_c && level;
            if (sampled == level) begin
                db_cnt <= '0;
            end else if (commit_c) begin
                db_cnt <= '0;
                level  <= sampled;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

`ifdef BOARD_CTRL_KEY_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_active;
    logic             rpt_hit_c;

    // First repeat after the delay, later ones after the rate interval.
    assign rpt_hit_c  = level && !commit_c &&
                        (rpt_cnt == (rpt_active ? RPT_W'(REPEAT_RATE_CYCLES - 1)
                                                : RPT_W'(REPEAT_DELAY_CYCLES - 1)));
    assign rpt_fire_c = REPEAT_ALLOW && rpt_hit_c;

    // Hold-time counter, restarted by every press and cleared while released.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt    <= '0;
            rpt_active <= 1'b0;
        end else if (!level || commit_c) begin
            rpt_cnt    <= '0;
            rpt_active <= 1'b0;
        end else if (rpt_hit_c) begin
            rpt_cnt    <= '0;
            rpt_active <= 1'b1;
        end else begin
            rpt_cnt    <= rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign rpt_fire_c = 1'b0;
`endif

endmodule

// File: rtl/board_ctrl.sv
// Board housekeeping: stretched system reset, debounced keypad and the
// character flash clock. Build option BOARD_CTRL_KEY_REPEAT_EN enables
// key auto-repeat (never on the reset key).
module board_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int unsigned NUM_KEYS            = 4,
    parameter bit          KEY_ACTIVE_LOW      = 1'b1,
    parameter int unsigned RST_KEY             = 2,
    parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned POR_CYCLES          = DEF_POR_CYCLES,
    parameter int unsigned FLASH_HALF_CYCLES   = DEF_FLASH_HALF_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic                CLK_14M,
    input  logic                reset,
    input  logic                pll_locked,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic                sys_reset,
    output logic                flash_clk,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [3:0]          led
);

    localparam int unsigned KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned POR_W   = cnt_width(POR_CYCLES);
    localparam int unsigned FLASH_W = cnt_width(FLASH_HALF_CYCLES);

    // Reject configurations outside the supported range.
    if (NUM_KEYS < 2 || NUM_KEYS > 8 || RST_KEY >= NUM_KEYS ||
        POR_CYCLES < 1 || FLASH_HALF_CYCLES < 1) begin : g_bad_cfg
        $error("board_ctrl: unsupported parameter combination");
    end

    // One debouncer per button; the reset key never auto-repeats.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
            .ACTIVE_LOW          (KEY_ACTIVE_LOW),
            .REPEAT_ALLOW        (k != int'(RST_KEY))
        ) u_key (
            .clk         (CLK_14M),
            .reset       (reset),
            .key_raw     (keys_in[k]),
            .level       (key_level[k]),
            .press_stb   (key_press[k]),
            .release_stb (key_release[k])
        );
    end

    por_state_t         state;
    por_state_t         state_next;
    logic [POR_W-1:0]   por_cnt;
    logic [POR_W-1:0]   por_cnt_next;
    logic [FLASH_W-1:0] flash_cnt;
    logic               cause_c;
    logic               run_c;

    assign cause_c = !pll_locked || key_level[KEY_W'(RST_KEY)];
    assign run_c   = (state == POR_RUN) && (state_next == POR_RUN);

    // POR next state: wait for causes to clear, stretch, run; causes win.
    always_comb begin
        state_next   = state;
        por_cnt_next = '0;
        case (state)
            POR_HOLD: begin
                if (!cause_c) state_next = POR_COUNT;
            end
            POR_COUNT: begin
                if (por_cnt == POR_W'(POR_CYCLES - 1)) state_next = POR_RUN;
                else                                  por_cnt_next = por_cnt + POR_W'(1);
            end
            POR_RUN: begin
                state_next = POR_RUN;
            end
            default: begin
                state_next = POR_HOLD;
            end
        endcase
        if (cause_c) begin
            state_next   = POR_HOLD;
            por_cnt_next = '0;
        end
    end

    // POR state register and registered system reset.
    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            state     <= POR_HOLD;
            por_cnt   <= '0;
            sys_reset <= 1'b1;
        end else begin
            state     <= state_next;
            por_cnt   <= por_cnt_next;
            sys_reset <= (state_next != POR_RUN);
        end
    end

    // Flash divider: free-runs only while staying in POR_RUN.
    always_ff @(posedge CLK_14M) begin
        if (reset || !run_c) begin
            flash_cnt <= '0;
            flash_clk <= 1'b0;
        end else if (flash_cnt == FLASH_W'(FLASH_HALF_CYCLES - 1)) begin
            flash_cnt <= '0;
            flash_clk <= !flash_clk;
        end else begin
            flash_cnt <= flash_cnt + FLASH_W'(1);
        end
    end

    // Status LEDs, one register behind their sources.
    always_ff @(posedge CLK_14M) begin
        if (reset) led <= 4'b0000;
        else       led <= {key_level[1:0], flash_clk, !sys_reset};
    end

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl with a cycle-level behavioural model.
module tb_board_ctrl;

    localparam int NK  = 4;
    localparam int DEB = 4;
    localparam int POR = 16;
    localparam int FL  = 8;
    localparam int RD  = 20;
    localparam int RR  = 10;
    localparam int RST = 2;
`ifdef BOARD_CTRL_KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          pll_locked;
    logic [NK-1:0] keys_in;
    logic          sys_reset;
    logic          flash_clk;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [3:0]    led;

    int vectors;
    int miscompares;
    int cyc;

    // Model state: pressed-value sample history per key and derived outputs.
    bit          xs [NK][8192];
    bit [NK-1:0] m_level, m_press, m_release;
    bit          m_sys_reset, m_flash;
    bit [3:0]    m_led;
    int          clr_run;
    int          press_edge [NK];

    logic [17:0] got, exp_v;

    board_ctrl #(
        .NUM_KEYS            (NK),
        .KEY_ACTIVE_LOW      (1'b1),
        .RST_KEY             (RST),
        .DEBOUNCE_CYCLES     (DEB),
        .POR_CYCLES          (POR),
        .FLASH_HALF_CYCLES   (FL),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_RATE_CYCLES  (RR)
    ) dut (
        .CLK_14M     (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .keys_in     (keys_in),
        .sys_reset   (sys_reset),
        .flash_clk   (flash_clk),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, update the model from the rules, then settle.
    task automatic tick();
        bit [NK-1:0] prev_level;
        bit          prev_flash, prev_sys, cause, commit;
        int          held;
        @(posedge clk);
        cyc++;
        prev_level = m_level;
        prev_flash = m_flash;
        prev_sys   = m_sys_reset;
        for (int k = 0; k < NK; k++) xs[k][cyc] = reset ? 1'b0 : !keys_in[k];
        if (reset) begin
            for (int k = 0; k < NK; k++) begin
                xs[k][cyc-1] = 1'b0;
                xs[k][cyc-2] = 1'b0;
            end
            m_level = '0; m_press = '0; m_release = '0;
            clr_run = 0; m_sys_reset = 1'b1; m_flash = 1'b0; m_led = '0;
        end else begin
            m_press = '0; m_release = '0;
            for (int k = 0; k < NK; k++) begin
                // Level flips once the last DEB synchronised samples all disagree.
                commit = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (xs[k][cyc-3-j] == prev_level[k]) commit = 1'b0;
                if (commit) begin
                    m_level[k] = !prev_level[k];
                    if (m_level[k]) begin
                        m_press[k]    = 1'b1;
                        press_edge[k] = cyc;
                    end else begin
                        m_release[k]  = 1'b1;
                    end
                end else if (REPEAT_ON && prev_level[k] && k != RST) begin
                    held = cyc - press_edge[k];
                    if (held >= RD && (held - RD) % RR == 0) m_press[k] = 1'b1;
                end
            end
            cause       = !pll_locked || prev_level[RST];
            clr_run     = cause ? 0 : clr_run + 1;
            m_sys_reset = (clr_run < POR + 1);
            m_flash     = m_sys_reset ? 1'b0 : (((clr_run - POR - 1) / FL) % 2 == 1);
            m_led       = {prev_level[1:0], prev_flash, !prev_sys};
        end
        #1;
    endtask

    task automatic bring_up();
        reset = 1'b1; pll_locked = 1'b1; keys_in = '1;
        repeat (4) tick();
        reset = 1'b0;
        repeat (POR + 1) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'($urandom_range(0, 1));
            keys_in    = NK'($urandom);
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            vectors++;
            if (got !== {1'b1, 17'b0}) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, got, {1'b1, 17'b0});
            end
        end
    endtask

    task automatic test_por_release();
        int fall_at, led_at;
        fall_at = -1; led_at = -1;
        reset = 1'b1; pll_locked = 1'b1; keys_in = '1;
        repeat (4) tick();
        reset = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL por_release cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (fall_at < 0 && sys_reset === 1'b0) fall_at = i;
            if (led_at < 0 && led[0] === 1'b1) led_at = i;
        end
        vectors++;
        if (fall_at !== POR + 1) begin
            miscompares++;
            $display("FAIL por_release_edge got=%0d exp=%0d", fall_at, POR + 1);
        end
        vectors++;
        if (led_at !== POR + 2) begin
            miscompares++;
            $display("FAIL por_led0_edge got=%0d exp=%0d", led_at, POR + 2);
        end
    endtask

    task automatic test_debounce();
        int n_press, n_rel, press_at, rel_at;
        bring_up();
        n_press = 0;
        keys_in[0] = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            if (i == 4) keys_in[0] = 1'b1;
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (key_press[0] === 1'b1) n_press++;
        end
        vectors++;
        if (n_press !== 0 || key_level[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_strobe got=%0d/%b exp=0/0", n_press, key_level[0]);
        end
        keys_in[0] = 1'b0; n_press = 0; press_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL press cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (key_press[0] === 1'b1) begin
                n_press++;
                if (press_at < 0) press_at = i;
            end
        end
        vectors++;
        if (press_at !== 1 + 2 + DEB || n_press !== 1 || key_level[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL press_edge got=%0d/%0d/%b exp=%0d/1/1", press_at, n_press, key_level[0], 1 + 2 + DEB);
        end
        keys_in[0] = 1'b1; n_rel = 0; rel_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL release cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (key_release[0] === 1'b1) begin
                n_rel++;
                if (rel_at < 0) rel_at = i;
            end
        end
        vectors++;
        if (rel_at !== 1 + 2 + DEB || n_rel !== 1 || key_level[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL release_edge got=%0d/%0d/%b exp=%0d/1/0", rel_at, n_rel, key_level[0], 1 + 2 + DEB);
        end
    endtask

    task automatic test_reset_key();
        int lvl_at, sr_at, fall_at, srf_at;
        bit flash_at_sr;
        bring_up();
        lvl_at = -1; sr_at = -1; flash_at_sr = 1'b1;
        keys_in[RST] = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL rst_key_press cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (lvl_at < 0 && key_level[RST] === 1'b1) lvl_at = i;
            if (sr_at < 0 && sys_reset === 1'b1) begin
                sr_at = i;
                flash_at_sr = flash_clk;
            end
        end
        vectors++;
        if (lvl_at !== 1 + 2 + DEB || sr_at !== lvl_at + 1 || flash_at_sr !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_key_assert got=%0d/%0d/%b exp=%0d/%0d/0", lvl_at, sr_at, flash_at_sr, 1 + 2 + DEB, 2 + 2 + DEB);
        end
        keys_in[RST] = 1'b1; fall_at = -1; srf_at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL rst_key_release cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (fall_at < 0 && key_level[RST] === 1'b0) fall_at = i;
            if (srf_at < 0 && fall_at >= 0 && sys_reset === 1'b0) srf_at = i;
        end
        vectors++;
        if (fall_at < 0 || srf_at !== fall_at + POR + 1) begin
            miscompares++;
            $display("FAIL rst_key_rerelease got=%0d exp=%0d", srf_at - fall_at, POR + 1);
        end
    endtask

    task automatic test_pll_loss();
        int fall_at;
        fall_at = -1;
        reset = 1'b1; pll_locked = 1'b1; keys_in = '1;
        repeat (4) tick();
        reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            pll_locked = (i != POR + 1);
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL pll_loss cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (fall_at < 0 && sys_reset === 1'b0) fall_at = i;
        end
        vectors++;
        if (fall_at !== 2 * (POR + 1)) begin
            miscompares++;
            $display("FAIL pll_loss_restart got=%0d exp=%0d", fall_at, 2 * (POR + 1));
        end
    endtask

    task automatic test_flash();
        int rise1, fall1, rise2;
        bit prev;
        bring_up();
        rise1 = -1; fall1 = -1; rise2 = -1; prev = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL flash cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (flash_clk === 1'b1 && !prev) begin
                if (rise1 < 0) rise1 = i;
                else if (rise2 < 0) rise2 = i;
            end
            if (flash_clk === 1'b0 && prev && fall1 < 0) fall1 = i;
            prev = (flash_clk === 1'b1);
        end
        vectors++;
        if (rise1 !== FL || fall1 !== 2 * FL || rise2 !== 3 * FL) begin
            miscompares++;
            $display("FAIL flash_edges got=%0d/%0d/%0d exp=%0d/%0d/%0d", rise1, fall1, rise2, FL, 2 * FL, 3 * FL);
        end
        pll_locked = 1'b0;
        tick();
        vectors++;
        if (flash_clk !== 1'b0 || sys_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL flash_pll_drop got=%b/%b exp=0/1", flash_clk, sys_reset);
        end
        pll_locked = 1'b1;
    endtask

    task automatic test_repeat();
        int seen [$];
        int want [$];
        bring_up();
        keys_in[1] = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            if (i == 61) keys_in[1] = 1'b1;
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL repeat cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (key_press[1] === 1'b1) seen.push_back(i);
        end
        want.push_back(1 + 2 + DEB);
        if (REPEAT_ON)
            for (int t = 1 + 2 + DEB + RD; t <= 60; t += RR) want.push_back(t);
        vectors++;
        if (seen.size() !== want.size()) begin
            miscompares++;
            $display("FAIL repeat_count got=%0d exp=%0d", seen.size(), want.size());
        end else begin
            for (int n = 0; n < want.size(); n++) begin
                vectors++;
                if (seen[n] !== want[n]) begin
                    miscompares++;
                    $display("FAIL repeat_edge%0d got=%0d exp=%0d", n, seen[n], want[n]);
                end
            end
        end
    endtask

    task automatic test_random();
        reset = 1'b1; pll_locked = 1'b1; keys_in = '1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 9) == 0) keys_in[k] = !keys_in[k];
            if (pll_locked) pll_locked = ($urandom_range(0, 149) != 0);
            else            pll_locked = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
            got = {sys_reset, flash_clk, key_level, key_press, key_release, led};
            exp_v = {m_sys_reset, m_flash, m_level, m_press, m_release, m_led};
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 16;
        clr_run = 0; m_level = '0; m_press = '0; m_release = '0;
        m_sys_reset = 1'b1; m_flash = 1'b0; m_led = '0;
        for (int k = 0; k < NK; k++) press_edge[k] = 0;
        reset = 1'b1; pll_locked = 1'b1; keys_in = '1;
        test_reset();
        test_por_release();
        test_debounce();
        test_reset_key();
        test_pll_loss();
        test_flash();
        test_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
